// File: rtl/hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Hazard controller for the EXE stage of the MIPS pipeline. It does five jobs:
//   * chooses forwarding sources for the three EX operands,
//   * detects load-use hazards, or any RAW hazard when forwarding is disabled,
//     and holds the front end while a NOP bubble goes into ID/EX,
//   * freezes the whole pipe while a data-memory access is outstanding,
//   * flushes the front end on a taken branch,
//   * counts stall and flush cycles and runs a memory-wait watchdog.
//
// Parameters
//   FWD_EN       1: forwarding on; 0: selects stay at 00 and every RAW stalls
//   MEM_TIMEOUT  wait cycles before mem_timeout_err is set (8-bit compare)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   id_src1/2, id_two_src          ID-stage source registers
//   ex_src1/2, ex_val2_is_reg      EX-stage source registers
//   ex_dest/wb_en/mem_r_en         EX-stage producer (a load when mem_r_en is 1)
//   mem_dest/wb_en, wb_dest/wb_en  MEM and WB producers
//   mem_req, mem_ready             data-memory handshake
//   br_taken                       branch resolved taken in EX
//   val1/2/3_forward_sel           00 reg, 01 MEM result, 10 WB result
//   freeze_front, bubble_idex      load-use / RAW stall
//   freeze_all                     hold every pipeline register and the PC
//   flush_front                    clear IF/ID and ID/EX
//   stall_cnt, flush_cnt           saturating performance counters
//   mem_timeout_err                sticky watchdog error
// ---------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter bit FWD_EN      = 1'b1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic [4:0]       ex_src1,
    input  logic [4:0]       ex_src2,
    input  logic             ex_val2_is_reg,
    input  logic [4:0]       ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [4:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic [1:0]       val1_forward_sel,
    output logic [1:0]       val2_forward_sel,
    output logic [1:0]       val3_forward_sel,
    output logic             freeze_front,
    output logic             bubble_idex,
    output logic             freeze_all,
    output logic             flush_front,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [7:0] TIMEOUT8 = 8'(MEM_TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_inc;
    logic       id_match_ex;
    logic       id_match_mem;
    logic       stall_req;

    // $0 is hard-wired to zero, so it never creates a dependence.
    function automatic logic reg_match(input logic [4:0] src,
                                       input logic [4:0] dest,
                                       input logic       wb_en);
        return wb_en && (dest != 5'd0) && (src == dest);
    endfunction

    // The MEM result is younger than the WB result, so MEM wins.
    function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                            input logic [4:0] m_dest,
                                            input logic       m_en,
                                            input logic [4:0] w_dest,
                                            input logic       w_en);
        if (reg_match(src, m_dest, m_en))
            return 2'b01;
        else if (reg_match(src, w_dest, w_en))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Forwarding selects. val3 is the store/branch operand, so it follows
    // ex_src2 even when the ALU's second input is an immediate.
    always_comb begin
        val1_forward_sel = 2'b00;
        val2_forward_sel = 2'b00;
        val3_forward_sel = 2'b00;
        if (FWD_EN) begin
            val1_forward_sel = fwd_pick(ex_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
            val3_forward_sel = fwd_pick(ex_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
            if (ex_val2_is_reg)
                val2_forward_sel = val3_forward_sel;
        end
    end

    // Stall detection and priority resolution. A memory freeze holds the
    // whole pipe, so a front-end stall is redundant there. A flush throws
    // away the dependent instruction in ID, so its stall is dropped too.
    // A branch held in EX by a freeze flushes in the first unfrozen cycle.
    always_comb begin
        id_match_ex  = reg_match(id_src1, ex_dest, ex_wb_en) ||
                       (id_two_src && reg_match(id_src2, ex_dest, ex_wb_en));
        id_match_mem = reg_match(id_src1, mem_dest, mem_wb_en) ||
                       (id_two_src && reg_match(id_src2, mem_dest, mem_wb_en));
        if (FWD_EN)
            stall_req = ex_mem_r_en && id_match_ex;
        else
            stall_req = id_match_ex || id_match_mem;

        freeze_all   = mem_req && !mem_ready;
        flush_front  = br_taken && !freeze_all;
        freeze_front = stall_req && !freeze_all && !flush_front;
        bubble_idex  = freeze_front;
    end

    assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    // Memory-wait FSM and watchdog. The wait counter only runs while an
    // access is still outstanding in MEM_WAIT. Leaving MEM_WAIT, either on
    // mem_ready or because the requester dropped mem_req, clears it. The
    // error is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            wait_cnt        <= 8'd0;
            mem_timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= 8'd0;
                    if (freeze_all)
                        state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (freeze_all) begin
                        wait_cnt <= wait_inc;
                        if (wait_inc >= TIMEOUT8)
                            mem_timeout_err <= 1'b1;
                    end else begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Performance counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze_front || freeze_all) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_front && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_ctrl
//
// Bench for hazard_forward_ctrl. It uses three instances that share one set
// of inputs:
//   dut        forwarding on, MEM_TIMEOUT=4 so the watchdog trips quickly
//   dut_nofwd  forwarding off, for the RAW-stall behaviour
//   dut_small  CNT_W=2, so counter saturation shows up within a few cycles
// Each vector holds inputs and expected outputs. applyStimulus drives the
// inputs and queues the expectation together with a snapshot of the bench's
// counter model. checkOutput pops the expectation at the falling edge and
// compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_hazard_forward_ctrl;

    typedef struct packed {
        logic [4:0] id_src1;
        logic [4:0] id_src2;
        logic       id_two_src;
        logic [4:0] ex_src1;
        logic [4:0] ex_src2;
        logic       ex_val2_is_reg;
        logic [4:0] ex_dest;
        logic       ex_wb_en;
        logic       ex_mem_r_en;
        logic [4:0] mem_dest;
        logic       mem_wb_en;
        logic [4:0] wb_dest;
        logic       wb_wb_en;
        logic       mem_req;
        logic       mem_ready;
        logic       br_taken;
    } in_t;

    typedef struct {
        in_t        in;
        logic [1:0] s1, s2, s3;
        logic       ff, fa, fl, nf, err;
        int         exp_stall, exp_flush;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] id_src1, id_src2, ex_src1, ex_src2, ex_dest, mem_dest, wb_dest;
    logic       id_two_src, ex_val2_is_reg, ex_wb_en, ex_mem_r_en, mem_wb_en;
    logic       wb_wb_en, mem_req, mem_ready, br_taken;

    logic [1:0]  sel1, sel2, sel3, nsel1, nsel2, nsel3, ssel1, ssel2, ssel3;
    logic        ff, bub, fa, fl, nff, nbub, nfa, nfl, sff, sbub, sfa, sfl;
    logic [15:0] stall_cnt, flush_cnt, nstall, nflush;
    logic [1:0]  sstall, sflush;
    logic        err, nerr, serr;

    hazard_forward_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_val2_is_reg(ex_val2_is_reg), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
        .ex_mem_r_en(ex_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .mem_req(mem_req),
        .mem_ready(mem_ready), .br_taken(br_taken),
        .val1_forward_sel(sel1), .val2_forward_sel(sel2), .val3_forward_sel(sel3),
        .freeze_front(ff), .bubble_idex(bub), .freeze_all(fa), .flush_front(fl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout_err(err));

    hazard_forward_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(255), .CNT_W(16)) dut_nofwd (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_val2_is_reg(ex_val2_is_reg), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
        .ex_mem_r_en(ex_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .mem_req(mem_req),
        .mem_ready(mem_ready), .br_taken(br_taken),
        .val1_forward_sel(nsel1), .val2_forward_sel(nsel2), .val3_forward_sel(nsel3),
        .freeze_front(nff), .bubble_idex(nbub), .freeze_all(nfa), .flush_front(nfl),
        .stall_cnt(nstall), .flush_cnt(nflush), .mem_timeout_err(nerr));

    hazard_forward_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(255), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_val2_is_reg(ex_val2_is_reg), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
        .ex_mem_r_en(ex_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .mem_req(mem_req),
        .mem_ready(mem_ready), .br_taken(br_taken),
        .val1_forward_sel(ssel1), .val2_forward_sel(ssel2), .val3_forward_sel(ssel3),
        .freeze_front(sff), .bubble_idex(sbub), .freeze_all(sfa), .flush_front(sfl),
        .stall_cnt(sstall), .flush_cnt(sflush), .mem_timeout_err(serr));

    int   n_vec  = 0;
    int   n_miss = 0;
    int   model_stall = 0;
    int   model_flush = 0;
    vec_t exp_q[$];
    vec_t tbl[14];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic in_t mki(input logic [4:0] i1, input logic [4:0] i2, input logic two,
                                input logic [4:0] e1, input logic [4:0] e2, input logic isreg,
                                input logic [4:0] ed, input logic ewb, input logic eld,
                                input logic [4:0] md, input logic mwb,
                                input logic [4:0] wd, input logic wwb,
                                input logic req, input logic rdy, input logic br);
        in_t r;
        r.id_src1 = i1;   r.id_src2 = i2;     r.id_two_src = two;
        r.ex_src1 = e1;   r.ex_src2 = e2;     r.ex_val2_is_reg = isreg;
        r.ex_dest = ed;   r.ex_wb_en = ewb;   r.ex_mem_r_en = eld;
        r.mem_dest = md;  r.mem_wb_en = mwb;
        r.wb_dest = wd;   r.wb_wb_en = wwb;
        r.mem_req = req;  r.mem_ready = rdy;  r.br_taken = br;
        return r;
    endfunction

    function automatic vec_t mkv(input in_t i, input logic [1:0] s1, input logic [1:0] s2,
                                 input logic [1:0] s3, input logic ffe, input logic fae,
                                 input logic fle, input logic nfe);
        vec_t v;
        v.in = i;  v.s1 = s1; v.s2 = s2; v.s3 = s3;
        v.ff = ffe; v.fa = fae; v.fl = fle; v.nf = nfe; v.err = 1'b0;
        v.exp_stall = 0; v.exp_flush = 0;
        return v;
    endfunction

    task automatic driveInputs(input in_t i);
        id_src1 = i.id_src1;   id_src2 = i.id_src2;    id_two_src = i.id_two_src;
        ex_src1 = i.ex_src1;   ex_src2 = i.ex_src2;    ex_val2_is_reg = i.ex_val2_is_reg;
        ex_dest = i.ex_dest;   ex_wb_en = i.ex_wb_en;  ex_mem_r_en = i.ex_mem_r_en;
        mem_dest = i.mem_dest; mem_wb_en = i.mem_wb_en;
        wb_dest = i.wb_dest;   wb_wb_en = i.wb_wb_en;
        mem_req = i.mem_req;   mem_ready = i.mem_ready; br_taken = i.br_taken;
    endtask

    // The counter snapshot is what the registered counters should show in
    // this vector's cycle. The model is then advanced for this cycle's edge.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        driveInputs(v.in);
        v.exp_stall = model_stall;
        v.exp_flush = model_flush;
        exp_q.push_back(v);
        if (v.ff || v.fa) model_stall++;
        if (v.fl) model_flush++;
    endtask

    task automatic checkOutput();
        vec_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            compare("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            compare("val1_sel", sel1, e.s1);
            compare("val2_sel", sel2, e.s2);
            compare("val3_sel", sel3, e.s3);
            compare("freeze_front", ff, e.ff);
            compare("bubble_idex", bub, e.ff);
            compare("freeze_all", fa, e.fa);
            compare("flush_front", fl, e.fl);
            compare("nofwd_freeze_front", nff, e.nf);
            compare("nofwd_sels", {nsel1, nsel2, nsel3}, 0);
            compare("stall_cnt", stall_cnt, e.exp_stall);
            compare("flush_cnt", flush_cnt, e.exp_flush);
            compare("mem_timeout_err", err, e.err);
            compare("small_stall_cnt_sat", sstall, (e.exp_stall > 3) ? 3 : e.exp_stall);
        end
    endtask

    task automatic run(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        driveInputs('0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset_stall_cnt", stall_cnt, 0);
        compare("reset_flush_cnt", flush_cnt, 0);
        compare("reset_timeout_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_stall = 0;
        model_flush = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        in_t  idle;
        idle = '0;
        rst  = 1'b1;
        driveInputs(idle);

        //           id1 id2 two ex1 ex2 reg exd ewb eld md mwb wd wwb req rdy br
        tbl[0]  = mkv(mki(0,0,0, 3,3,1, 0,0,0, 3,1, 0,0, 0,0,0), 1,1,1, 0,0,0,0);
        tbl[1]  = mkv(mki(0,0,0, 3,3,1, 0,0,0, 3,1, 3,1, 0,0,0), 1,1,1, 0,0,0,0);
        tbl[2]  = mkv(mki(0,0,0, 3,3,1, 0,0,0, 3,0, 3,1, 0,0,0), 2,2,2, 0,0,0,0);
        tbl[3]  = mkv(mki(0,0,0, 7,3,0, 0,0,0, 3,1, 7,1, 0,0,0), 2,0,1, 0,0,0,0);
        tbl[4]  = mkv(mki(0,0,0, 0,0,1, 0,1,1, 0,1, 0,1, 0,0,0), 0,0,0, 0,0,0,0);
        tbl[5]  = mkv(mki(0,0,0, 4,4,1, 0,0,0, 4,0, 0,0, 0,0,0), 0,0,0, 0,0,0,0);
        tbl[6]  = mkv(mki(5,0,0, 0,0,0, 5,1,1, 0,0, 0,0, 0,0,0), 0,0,0, 1,0,0,1);
        tbl[7]  = mkv(mki(6,5,0, 0,0,0, 5,1,1, 0,0, 0,0, 0,0,0), 0,0,0, 0,0,0,0);
        tbl[8]  = mkv(mki(6,5,1, 0,0,0, 5,1,1, 0,0, 0,0, 0,0,0), 0,0,0, 1,0,0,1);
        tbl[9]  = mkv(mki(5,0,0, 0,0,0, 5,1,1, 0,0, 0,0, 0,0,1), 0,0,0, 0,0,1,0);
        tbl[10] = mkv(mki(5,0,0, 0,0,0, 5,1,0, 0,0, 0,0, 0,0,0), 0,0,0, 0,0,0,1);
        tbl[11] = mkv(mki(9,0,0, 0,0,0, 0,0,0, 9,1, 0,0, 0,0,0), 0,0,0, 0,0,0,1);
        tbl[12] = mkv(mki(5,0,0, 0,0,0, 5,1,1, 0,0, 0,0, 1,0,1), 0,0,0, 0,1,0,0);
        tbl[13] = mkv(mki(5,0,0, 0,0,0, 5,0,1, 0,0, 0,0, 0,0,0), 0,0,0, 0,0,0,0);

        $display("[TB] reset and table vectors");
        doReset();
        for (int i = 0; i < 14; i++)
            run(tbl[i]);

        $display("[TB] load-use sequence");
        doReset();
        run(mkv(mki(5,0,0, 0,0,0, 5,1,1, 0,0, 0,0, 0,0,0), 0,0,0, 1,0,0,1));
        run(mkv(mki(5,0,0, 0,0,0, 0,0,0, 5,1, 0,0, 0,0,0), 0,0,0, 0,0,0,1));
        run(mkv(mki(0,0,0, 5,0,0, 0,0,0, 0,0, 5,1, 0,0,0), 2,0,0, 0,0,0,0));

        $display("[TB] multicycle memory access");
        for (int i = 0; i < 3; i++)
            run(mkv(mki(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 1,0,0), 0,0,0, 0,1,0,0));
        run(mkv(mki(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 1,1,0), 0,0,0, 0,0,0,0));
        run(mkv(idle, 0,0,0, 0,0,0,0));

        $display("[TB] branch under freeze");
        run(mkv(mki(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 1,0,1), 0,0,0, 0,1,0,0));
        run(mkv(mki(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 1,1,1), 0,0,0, 0,0,1,0));
        run(mkv(idle, 0,0,0, 0,0,0,0));

        $display("[TB] watchdog");
        for (int i = 0; i < 7; i++) begin
            v = mkv(mki(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 1,0,0), 0,0,0, 0,1,0,0);
            v.err = (i >= 5);
            run(v);
        end
        v = mkv(idle, 0,0,0, 0,0,0,0);
        v.err = 1'b1;
        run(v);
        run(v);
        doReset();
        run(mkv(idle, 0,0,0, 0,0,0,0));

        $display("[TB] forwarding disabled RAW stall");
        run(mkv(mki(3,0,0, 0,0,0, 3,1,0, 0,0, 0,0, 0,0,0), 0,0,0, 0,0,0,1));
        run(mkv(mki(3,0,0, 0,0,0, 0,0,0, 3,1, 0,0, 0,0,0), 0,0,0, 0,0,0,1));
        run(mkv(mki(3,0,0, 0,0,0, 0,0,0, 0,0, 3,1, 0,0,0), 0,0,0, 0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
